// File: rtl/imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb
// Purpose  : Shares one instruction-memory port between the fetch stage and
//            the loader/debug port. Fetch has fixed priority. A starvation
//            counter promotes a waiting loader, and a burst lock lets the
//            loader own the port. Read data and responses are registered.
// Option   : IMEM_ARB_MISALIGN_CHK_EN adds the err output. Misaligned or
//            out-of-range accesses then return 0 and flag err.
// Revision : 1.0  initial release
// ============================================================================
module imem_arb #(
  parameter int DEPTH_WORDS = 64,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
`ifdef IMEM_ARB_MISALIGN_CHK_EN
  ,
  output logic        err
`endif
);

  localparam logic [0:0]  c_IDLE       = 1'b0;
  localparam logic [0:0]  c_LOCKED     = 1'b1;
  localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_MAX);
  localparam logic [29:0] c_DEPTH      = 30'(DEPTH_WORDS);

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic [3:0]  r_starve;
  logic        r_f_rvalid;
  logic [31:0] r_f_rdata;
  logic        r_l_rvalid;
  logic [31:0] r_l_rdata;

  // Address qualification. A "bad" read returns 0 instead of memory data;
  // a write is only committed when it targets an existing, legal word.
  logic w_l_oor;
  logic w_f_bad;
  logic w_l_bad;
  logic w_l_wr_ok;

  assign w_l_oor = (l_addr[31:2] >= c_DEPTH);

`ifdef IMEM_ARB_MISALIGN_CHK_EN
  logic w_f_oor;
  logic r_err;
  assign w_f_oor   = (f_addr[31:2] >= c_DEPTH);
  assign w_f_bad   = w_f_oor || (f_addr[1:0] != 2'b00);
  assign w_l_bad   = w_l_oor || (l_addr[1:0] != 2'b00);
  assign w_l_wr_ok = !w_l_bad;
  assign err       = r_err;
`else
  assign w_f_bad   = 1'b0;
  assign w_l_bad   = 1'b0;
  assign w_l_wr_ok = !w_l_oor;
`endif

  // State register: burst-lock ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: lock on a locking loader grant, release as soon as l_lock drops.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (l_gnt && l_lock) w_next_state = c_LOCKED;
      c_LOCKED: if (!l_lock)         w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Grant decode. A LOCKED cycle with l_lock low is arbitrated as IDLE so a
  // waiting fetch gets the port in the very cycle the lock drops.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      if (r_state == c_LOCKED && l_lock) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        if (r_starve == c_STARVE_MAX) l_gnt = 1'b1;
        else                          f_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
  end

  assign m_addr  = l_gnt ? l_addr  : f_addr;
  assign m_wdata = l_gnt ? l_wdata : 32'h0;
  assign m_we    = l_gnt && l_we && w_l_wr_ok;

  // Starvation counter: counts denied loader cycles, saturating, cleared on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      r_starve <= 4'd0;
    else if (l_gnt)                                 r_starve <= 4'd0;
    else if (l_req && (r_starve != c_STARVE_MAX))   r_starve <= r_starve + 4'd1;
  end

  // Fetch response: one-cycle valid pulse, data held until the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= 32'h0;
    end else begin
      r_f_rvalid <= f_gnt;
      if (f_gnt) r_f_rdata <= w_f_bad ? 32'h0 : m_rdata;
    end
  end

  // Loader response: read data, or zero as the write acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l_rvalid <= 1'b0;
      r_l_rdata  <= 32'h0;
    end else begin
      r_l_rvalid <= l_gnt;
      if (l_gnt) r_l_rdata <= (l_we || w_l_bad) ? 32'h0 : m_rdata;
    end
  end

`ifdef IMEM_ARB_MISALIGN_CHK_EN
  // Error flag pulses alongside the response of a rejected access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= (f_gnt && w_f_bad) || (l_gnt && w_l_bad);
  end
`endif

  assign f_rvalid = r_f_rvalid;
  assign f_rdata  = r_f_rdata;
  assign l_rvalid = r_l_rvalid;
  assign l_rdata  = r_l_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arb
// Purpose  : Self-checking bench for imem_arb with a behavioural memory and
//            per-requester response scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_arb;

  localparam int c_DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, l_req, l_we, l_lock;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, m_we;
  logic [31:0] f_rdata, l_rdata, m_addr, m_wdata, m_rdata;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
  logic        err;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] fq[$];
  logic [31:0] lq[$];
  logic [31:0] mem [c_DEPTH];

  always #5 clk = ~clk;

  imem_arb #(.DEPTH_WORDS(c_DEPTH), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    , .err(err)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h00500113 : (32'hC0DE0000 ^ (i * 32'h01010101));
  endfunction

  function automatic logic [31:0] oor_val(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  // Behavioural memory: combinational read, synchronous write.
  assign m_rdata = (m_addr[31:2] < 30'(c_DEPTH)) ? mem[m_addr[7:2]] : oor_val(m_addr);

  initial for (int i = 0; i < c_DEPTH; i++) mem[i] = init_val(i);

  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (f_rvalid) begin
        if (fq.size() == 0) check("f_spurious_rvalid", 32'd1, 32'd0);
        else                check("f_rdata", f_rdata, fq.pop_front());
      end
      if (l_rvalid) begin
        if (lq.size() == 0) check("l_spurious_rvalid", 32'd1, 32'd0);
        else                check("l_rdata", l_rdata, lq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
  endtask

  task automatic drain(input string tag);
    cyc(); idle_inputs(); cyc(); cyc();
    check({tag, "_fq_empty"}, 32'(fq.size()), 32'd0);
    check({tag, "_lq_empty"}, 32'(lq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    check("rst_f_gnt",    32'(f_gnt),    32'd0);
    check("rst_l_gnt",    32'(l_gnt),    32'd0);
    check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check("rst_f_rdata",  f_rdata,       32'd0);
    check("rst_l_rdata",  l_rdata,       32'd0);
    check("rst_m_we",     32'(m_we),     32'd0);
    check("rst_starve",   32'(dut.r_starve), 32'd0);
    reset = 1'b0;

    // Fetch only.
    cyc();
    f_req = 1'b1; f_addr = 32'h0; #1;
    check("t1_f_gnt", 32'(f_gnt), 32'd1);
    check("t1_l_gnt", 32'(l_gnt), 32'd0);
    fq.push_back(32'h00500113);
    drain("t1");

    // Contention: fetch for 4 cycles, loader on the 5th, fetch again.
    for (int c = 0; c < 6; c++) begin
      cyc();
      f_req = 1'b1; f_addr = 32'h10;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20; #1;
      if (c == 3) check("t2_starve_c3", 32'(dut.r_starve), 32'd3);
      if (c == 5) check("t2_starve_c5", 32'(dut.r_starve), 32'd0);
      check($sformatf("t2_f_gnt_c%0d", c), 32'(f_gnt), (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("t2_l_gnt_c%0d", c), 32'(l_gnt), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) lq.push_back(init_val(8));
      else        fq.push_back(init_val(4));
    end
    // Let the denied loader finish so the counter is clear again.
    cyc(); f_req = 1'b0; #1;
    check("t2_l_gnt_tail", 32'(l_gnt), 32'd1);
    lq.push_back(init_val(8));
    drain("t2");

    // Loader write then fetch of the same word.
    cyc();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h54; l_wdata = 32'h00000013; #1;
    check("t3_l_gnt", 32'(l_gnt), 32'd1);
    check("t3_m_we",  32'(m_we),  32'd1);
    check("t3_m_addr", m_addr,    32'h54);
    lq.push_back(32'h0);
    cyc();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h54; #1;
    check("t3_f_gnt", 32'(f_gnt), 32'd1);
    fq.push_back(32'h00000013);
    drain("t3");

    // Lock burst of 3 writes; fetch waits, then wins when l_lock drops.
    for (int k = 0; k < 3; k++) begin
      cyc();
      f_req = (k != 0); f_addr = 32'h8;
      l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
      l_addr = 32'h60 + 32'(4 * k); l_wdata = 32'hA0000000 + 32'(k); #1;
      check($sformatf("t4_f_gnt_b%0d", k), 32'(f_gnt), 32'd0);
      check($sformatf("t4_l_gnt_b%0d", k), 32'(l_gnt), 32'd1);
      lq.push_back(32'h0);
    end
    cyc();
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; #1;
    check("t4_f_gnt_release", 32'(f_gnt), 32'd1);
    fq.push_back(init_val(2));
    for (int k = 0; k < 3; k++) begin
      cyc();
      f_addr = 32'h60 + 32'(4 * k); #1;
      check($sformatf("t4_f_gnt_rd%0d", k), 32'(f_gnt), 32'd1);
      fq.push_back(32'hA0000000 + 32'(k));
    end
    drain("t4");

    // Reset while locked with a loader response pending.
    cyc();
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b0; l_addr = 32'h4; #1;
    check("t5_l_gnt0", 32'(l_gnt), 32'd1);
    lq.push_back(init_val(1));
    cyc();
    f_req = 1'b1; f_addr = 32'hC; #1;
    check("t5_f_gnt_locked", 32'(f_gnt), 32'd0);
    check("t5_l_gnt1", 32'(l_gnt), 32'd1);
    lq.push_back(init_val(1));
    cyc();
    reset = 1'b1; #1;
    check("t5_rst_l_rvalid", 32'(l_rvalid), 32'd0);
    check("t5_rst_l_rdata",  l_rdata,       32'd0);
    check("t5_rst_f_gnt",    32'(f_gnt),    32'd0);
    check("t5_rst_l_gnt",    32'(l_gnt),    32'd0);
    check("t5_rst_state",    32'(dut.r_state), 32'd0);
    void'(lq.pop_front());
    l_req = 1'b0; l_lock = 1'b0;
    reset = 1'b0; #1;
    check("t5_f_gnt_after", 32'(f_gnt), 32'd1);
    check("t5_starve", 32'(dut.r_starve), 32'd0);
    fq.push_back(init_val(3));
    drain("t5");

    // Misaligned loader write to 0x06.
    cyc();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h06; l_wdata = 32'hBEEF0006; #1;
    check("t6_l_gnt", 32'(l_gnt), 32'd1);
    lq.push_back(32'h0);
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    check("t6_m_we", 32'(m_we), 32'd0);
    cyc();
    idle_inputs(); #1;
    check("t6_err", 32'(err), 32'd1);
    check("t6_l_rvalid", 32'(l_rvalid), 32'd1);
`else
    check("t6_m_we", 32'(m_we), 32'd1);
    cyc();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h4; #1;
    check("t6_f_gnt", 32'(f_gnt), 32'd1);
    fq.push_back(32'hBEEF0006);
`endif
    drain("t6");

    // Out-of-range write is suppressed but acknowledged; out-of-range read.
    cyc();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'h12345678; #1;
    check("t7_m_we_oor", 32'(m_we), 32'd0);
    lq.push_back(32'h0);
    cyc();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h104; #1;
    check("t7_f_gnt", 32'(f_gnt), 32'd1);
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    fq.push_back(32'h0);
`else
    fq.push_back(oor_val(32'h104));
`endif
    cyc();
    f_req = 1'b1; f_addr = 32'h0; #1;
    fq.push_back(32'h00500113);
    drain("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
